// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file read side.
package regfile_pkg;

  localparam int NUM_REGS_DEFAULT  = 32;
  localparam int BIT_WIDTH_DEFAULT = 32;
  localparam int ADDR_WIDTH_DEFAULT = $clog2(NUM_REGS_DEFAULT);

  typedef logic [ADDR_WIDTH_DEFAULT-1:0] reg_addr_t;
  typedef logic [BIT_WIDTH_DEFAULT-1:0]  reg_data_t;

  typedef struct packed {
    reg_data_t   a;
    reg_data_t   b;
    logic [1:0]  err;
  } read_entry_t;

  function automatic logic addr_in_range(input int addr, input int num_regs);
    return (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_read_select.sv
// Per-port operand select: range check, same-cycle write bypass and zero-register mux.
// Optional build macro: REGFILE_READ_PORT_ZERO_REG_EN (address 0 reads as zero).
module regfile_read_select
  import regfile_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEFAULT,
  parameter int NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*BIT_WIDTH-1:0] reg_values,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [BIT_WIDTH-1:0]          wr_data,
  output logic [BIT_WIDTH-1:0]          data,
  output logic                          err
);

`ifdef REGFILE_READ_PORT_ZERO_REG_EN
  localparam logic ZERO_REG_EN = 1'b1;
`else
  localparam logic ZERO_REG_EN = 1'b0;
`endif

  logic [BIT_WIDTH-1:0] slice;
  logic                 in_range;
  logic                 hit;

  // AND-OR mux over the flattened storage, then range/zero/bypass priority
  always_comb begin
    slice = {BIT_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      slice = slice | ({BIT_WIDTH{addr == ADDR_WIDTH'(k)}} & reg_values[k*BIT_WIDTH +: BIT_WIDTH]);
    end
    in_range = addr_in_range(int'(addr), NUM_REGS);
    hit      = wr_en && (wr_addr == addr);
    err      = 1'b0;
    if (!in_range) begin
      data = {BIT_WIDTH{1'b0}};
      err  = 1'b1;
    end else if (ZERO_REG_EN && (addr == {ADDR_WIDTH{1'b0}})) begin
      data = {BIT_WIDTH{1'b0}};
    end else if (hit) begin
      data = wr_data;
    end else begin
      data = slice;
    end
  end

endmodule

// File: rtl/regfile_read_port.sv
// Paired A/B read port with a 2-entry response buffer and same-cycle write bypass.
// Optional build macro: REGFILE_READ_PORT_ZERO_REG_EN (handled in regfile_read_select).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEFAULT,
  parameter int NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REGS*BIT_WIDTH-1:0] reg_values,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [BIT_WIDTH-1:0]          wr_data,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [BIT_WIDTH-1:0]          rsp_data_a,
  output logic [BIT_WIDTH-1:0]          rsp_data_b,
  output logic [1:0]                    rsp_err
);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic [1:0]           err;
  } entry_t;

  entry_t     entry_q [2];
  entry_t     entry_d [2];
  entry_t     head_q;
  entry_t     head_d;
  entry_t     new_entry;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rd_ready_q, rd_ready_d;
  logic       push;
  logic       pop;

  regfile_read_select #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sel_a (
    .reg_values(reg_values),
    .addr      (rd_addr_a),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data      (new_entry.a),
    .err       (new_entry.err[0])
  );

  regfile_read_select #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sel_b (
    .reg_values(reg_values),
    .addr      (rd_addr_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data      (new_entry.b),
    .err       (new_entry.err[1])
  );

  assign push = rd_valid && rd_ready_q;
  assign pop  = rsp_valid_q && rsp_ready;

  // Buffer bookkeeping; outputs are pre-computed from the next head so they come straight from flops
  always_comb begin
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;
    if (push) begin
      entry_d[wr_ptr_q] = new_entry;
      wr_ptr_d          = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // When empty, the last response stays on the outputs
    if (count_d != 2'd0) begin
      head_d = entry_d[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
    rsp_valid_d = (count_d != 2'd0);
    rd_ready_d  = (count_d != 2'd2);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q[0]  <= '0;
      entry_q[1]  <= '0;
      head_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rd_ready_q  <= 1'b1;
    end else begin
      entry_q[0]  <= entry_d[0];
      entry_q[1]  <= entry_d[1];
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rd_ready_q  <= rd_ready_d;
    end
  end

  assign rd_ready   = rd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data_a = head_q.a;
  assign rsp_data_b = head_q.b;
  assign rsp_err    = head_q.err;

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the register file: serves paired (A/B) read requests against the flattened outputs of the storage registers.
- Request channel is valid/ready; response channel is valid/ready.
- Fixed 1-cycle latency through a 2-entry response buffer.
- Same-cycle write bypass: a write issued in the acceptance cycle is visible in the returned data.
- Sits between the storage array and the operand-fetch consumer.

Parameters:
- BIT_WIDTH, 32, width of each register.
- NUM_REGS, 32, number of registers in the file (>= 2).
- ADDR_WIDTH, $clog2(NUM_REGS), address width.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_values  input  NUM_REGS*BIT_WIDTH  flattened storage outputs; register k occupies bits [k*BIT_WIDTH +: BIT_WIDTH].
- wr_en  input  1  storage write strobe, this cycle (snooped for bypass).
- wr_addr  input  ADDR_WIDTH  storage write address.
- wr_data  input  BIT_WIDTH  storage write data.
- rd_valid  input  1  read request valid.
- rd_ready  output  1  request accepted when rd_valid && rd_ready.
- rd_addr_a  input  ADDR_WIDTH  port A address.
- rd_addr_b  input  ADDR_WIDTH  port B address.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data_a  output  BIT_WIDTH  port A data.
- rsp_data_b  output  BIT_WIDTH  port B data.
- rsp_err  output  2  {b,a} address >= NUM_REGS flags.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: count=0, pointers=0, rsp_valid=0, rd_ready=1 from the first cycle after reset, rsp_data_a/b=0, rsp_err=0.
- Storage: 2-entry circular buffer; wr_ptr/rd_ptr are 1 bit each; count ranges 0..2.
- rd_ready: equals (count < 2), registered-state only. There is no combinational path from rsp_ready.
- Accept (rd_valid && rd_ready):
  - Snapshot data for each port: if wr_en && wr_addr==addr, use wr_data (bypass); else use the reg_values slice.
  - Out-of-range address: data=0 and the corresponding rsp_err bit=1; the bypass is ignored.
- Latency: an entry accepted in cycle N is visible on rsp_* in cycle N+1 when the buffer is empty.
- Ordering: responses are returned in request order.
- Pop: rsp_valid && rsp_ready.
- Response outputs: rsp_valid = (count != 0); rsp_data_*/rsp_err show the head entry. They hold stable while rsp_valid && !rsp_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. Legal at count 1. At count 2 the push is impossible, since rd_ready=0.
- Snapshot semantics: buffered entries are not updated by later writes. Stale data is the consumer's concern.
- rsp_valid=0: rsp_data_*/rsp_err hold their last value (not X).
- Reset mid-operation: buffered entries are discarded and no response is emitted for them.
- Bypass when both ports address the same register: both ports receive wr_data.

Optional Feature:
- Macro: REGFILE_READ_PORT_ZERO_REG_EN.
- Defined: address 0 always reads 0 on both ports, regardless of reg_values or a bypass write to address 0; rsp_err is unaffected.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package regfile_pkg holds:
  - constants NUM_REGS_DEFAULT and BIT_WIDTH_DEFAULT;
  - typedef reg_addr_t (ADDR_WIDTH bits);
  - typedef reg_data_t (BIT_WIDTH bits);
  - typedef read_entry_t {reg_data_t a, reg_data_t b, logic [1:0] err}.
- One sub-module, regfile_read_select: combinational address decode, range check, bypass compare and zero-register mux. Instantiated twice, once per port.
- The buffer and handshake stay in the top level.

Test Plan:
- Basic read: reset, reg_values with reg k = 32'h1000+k; request a=3, b=7 with rsp_ready=1 → next cycle rsp_valid=1, data_a=32'h1003, data_b=32'h1007, rsp_err=0.
- Bypass: request a=5, b=5 with wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF in the same cycle → both data = 32'hDEADBEEF. A write in the following cycle leaves the buffered entry unchanged.
- Backpressure: rsp_ready=0, three back-to-back requests (1,2), (3,4), (5,6):
  - first two accepted, then rd_ready=0 and the third is held;
  - rsp outputs stay at (32'h1001, 32'h1002);
  - after rsp_ready=1, responses drain in order.
- Simultaneous push and pop at count 1 over 10 cycles → throughput of one response per cycle, count stays 1, rd_ready never drops.
- Out-of-range and zero register with NUM_REGS=24: request a=30, b=0 → data_a=0, rsp_err=2'b01. data_b=0 with the macro defined, else 32'h1000.
- Reset mid-operation: fill 2 entries, assert reset for 1 cycle → rsp_valid=0, rd_ready=1 next cycle, and no stale response appears afterwards.
